// File: rtl/freq_ctrl_pkg.sv
// Shared definitions for the frequency-meter measurement sequencer.
//   state_t    : sequencer states
//   RANGE_*    : gate-time range codes (1 s, 100 ms, 10 ms, 1 ms)
//   gate_len() : gate length in clock cycles for a given range
package freq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_GATE,
        ST_SETTLE,
        ST_LATCH
    } state_t;

    localparam logic [1:0] RANGE_1S    = 2'd0;
    localparam logic [1:0] RANGE_100MS = 2'd1;
    localparam logic [1:0] RANGE_10MS  = 2'd2;
    localparam logic [1:0] RANGE_1MS   = 2'd3;

    // Gate length is CLK_HZ / 10^r cycles.
    function automatic int gate_len(input int clk_hz, input logic [1:0] r);
        case (r)
            RANGE_1S:    return clk_hz;
            RANGE_100MS: return clk_hz / 10;
            RANGE_10MS:  return clk_hz / 100;
            default:     return clk_hz / 1000;
        endcase
    endfunction

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter shared by the CLEAR, GATE and SETTLE phases.
//   clock, reset_n : clock, synchronous active-low reset
//   load           : start a new count from load_val (wins over counting)
//   load_val       : first count value; the phase lasts load_val+1 cycles
//   done           : high in the cycle the running count sits at zero
module gate_timer #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_reg;
    logic         busy_reg;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_reg <= '0;
            busy_reg  <= 1'b0;
        end else if (load) begin
            count_reg <= load_val;
            busy_reg  <= 1'b1;
        end else if (busy_reg) begin
            // Stop at zero instead of wrapping; done then falls.
            if (count_reg == '0) begin
                busy_reg <= 1'b0;
            end else begin
                count_reg <= count_reg - W'(1);
            end
        end
    end

    assign done = busy_reg && (count_reg == '0);

endmodule

// File: rtl/freq_gate_ctrl.sv
// Measurement sequencer for the TTL frequency meter: clears the BCD counter
// chain, opens a timed gate, waits for the chain to settle, latches the count
// and auto-ranges the gate time.
//   clock, reset_n : clock, synchronous active-low reset
//   run            : 1 = measure continuously, 0 = stop/abort
//   auto_range     : 1 = automatic range, 0 = range_sel
//   range_sel      : manual range 0..3
//   bcd_in         : counter chain digits, overflow_in : top-digit carry
//   clear, enable  : counter chain clear and gate
//   result_bcd, range, over_range, result_valid : published measurement
module freq_gate_ctrl
    import freq_ctrl_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int CLEAR_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        run,
    input  logic        auto_range,
    input  logic [1:0]  range_sel,
    input  logic [23:0] bcd_in,
    input  logic        overflow_in,
    output logic        clear,
    output logic        enable,
    output logic [23:0] result_bcd,
    output logic [1:0]  range,
    output logic        result_valid,
    output logic        over_range
);

    localparam int TW = $clog2(CLK_HZ + 1);

    state_t     state_reg;
    logic [1:0] active_reg;   // range of the measurement in progress
    logic [1:0] auto_reg;     // range the auto-ranger will use next
    logic       sticky_reg;   // overflow seen during GATE or SETTLE

    logic [1:0]    sel_range;
    logic          timer_load;
    logic [TW-1:0] timer_val;
    logic          timer_done;

    assign sel_range = auto_range ? auto_reg : range_sel;

    // The timer is loaded on the same edge that enters the next timed phase,
    // so every phase lasts exactly load_val+1 cycles.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = '0;
        case (state_reg)
            ST_IDLE: begin
                if (run) begin
                    timer_load = 1'b1;
                    timer_val  = TW'(CLEAR_CYCLES - 1);
                end
            end
            ST_CLEAR: begin
                if (run && timer_done) begin
                    timer_load = 1'b1;
                    timer_val  = TW'(gate_len(CLK_HZ, sel_range) - 1);
                end
            end
            ST_GATE: begin
                if (run && timer_done) begin
                    timer_load = 1'b1;
                    timer_val  = TW'(SETTLE_CYCLES - 1);
                end
            end
            ST_LATCH: begin
                if (run) begin
                    timer_load = 1'b1;
                    timer_val  = TW'(CLEAR_CYCLES - 1);
                end
            end
            default: ;
        endcase
    end

    gate_timer #(
        .W(TW)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (timer_load),
        .load_val(timer_val),
        .done    (timer_done)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            active_reg   <= RANGE_1S;
            auto_reg     <= RANGE_1S;
            sticky_reg   <= 1'b0;
            clear        <= 1'b1;
            enable       <= 1'b0;
            result_bcd   <= '0;
            range        <= RANGE_1S;
            result_valid <= 1'b0;
            over_range   <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    clear  <= 1'b1;
                    enable <= 1'b0;
                    if (run) begin
                        state_reg <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    sticky_reg <= 1'b0;
                    // Tracked every cycle; the value of the last CLEAR cycle
                    // is the one the gate length was computed from.
                    active_reg <= sel_range;
                    if (!run) begin
                        state_reg <= ST_IDLE;
                    end else if (timer_done) begin
                        state_reg <= ST_GATE;
                        clear     <= 1'b0;
                        enable    <= 1'b1;
                    end
                end
                ST_GATE: begin
                    if (overflow_in) begin
                        sticky_reg <= 1'b1;
                    end
                    if (!run) begin
                        state_reg <= ST_IDLE;
                        enable    <= 1'b0;
                        clear     <= 1'b1;
                    end else if (timer_done) begin
                        state_reg <= ST_SETTLE;
                        enable    <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (overflow_in) begin
                        sticky_reg <= 1'b1;
                    end
                    if (!run) begin
                        state_reg <= ST_IDLE;
                        clear     <= 1'b1;
                    end else if (timer_done) begin
                        state_reg <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    if (sticky_reg && auto_range && active_reg != RANGE_1MS) begin
                        // Too many counts: retry with a shorter gate, no publish.
                        auto_reg <= active_reg + 2'd1;
                    end else begin
                        result_valid <= 1'b1;
                        result_bcd   <= bcd_in;
                        range        <= active_reg;
                        over_range   <= sticky_reg;
                        // Leading digit unused: next gate is ten times longer.
                        if (!sticky_reg && auto_range && bcd_in[23:20] == 4'd0 &&
                            active_reg != RANGE_1S) begin
                            auto_reg <= active_reg - 2'd1;
                        end
                    end
                    clear     <= 1'b1;
                    enable    <= 1'b0;
                    state_reg <= run ? ST_CLEAR : ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    clear     <= 1'b1;
                    enable    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
module tb_freq_gate_ctrl;

    localparam int CLK_HZ = 1000;
    localparam int CLR    = 4;
    localparam int SET    = 16;
    localparam int BUDGET = 3000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic        auto_range = 1'b0;
    logic [1:0]  range_sel = 2'd0;
    logic [23:0] bcd_in = 24'd0;
    logic        overflow_in = 1'b0;
    logic        clear;
    logic        enable;
    logic [23:0] result_bcd;
    logic [1:0]  range;
    logic        result_valid;
    logic        over_range;

    freq_gate_ctrl #(
        .CLK_HZ(CLK_HZ),
        .CLEAR_CYCLES(CLR),
        .SETTLE_CYCLES(SET)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .run         (run),
        .auto_range  (auto_range),
        .range_sel   (range_sel),
        .bcd_in      (bcd_in),
        .overflow_in (overflow_in),
        .clear       (clear),
        .enable      (enable),
        .result_bcd  (result_bcd),
        .range       (range),
        .result_valid(result_valid),
        .over_range  (over_range)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [23:0] bcd;
        logic [1:0]  rng;
        logic        ovr;
    } res_t;

    res_t res_q[$];
    int   gate_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: gate length per range and the auto range.
    int   len_tab[4] = '{1000, 100, 10, 1};
    int   m_auto = 0;
    res_t last_pub = '{24'd0, 2'd0, 1'b0};

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic finish_bench();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_enable(input logic lvl);
        for (int i = 0; i < BUDGET; i++) begin
            if (enable == lvl) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL enable_timeout: enable stayed %0b, required %0b", enable, lvl);
        finish_bench();
    endtask

    task automatic wait_rise();
        wait_enable(1'b0);
        wait_enable(1'b1);
    endtask

    task automatic wait_results_drained();
        for (int i = 0; i < BUDGET; i++) begin
            if (res_q.size() == 0) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL publish_timeout: %0d results pending, required 0", res_q.size());
        finish_bench();
    endtask

    function automatic logic [23:0] rand_bcd(input bit top_zero);
        logic [23:0] v;
        for (int d = 0; d < 6; d++) v[d*4 +: 4] = 4'($urandom_range(0, 9));
        if (top_zero) v[23:20] = 4'd0;
        return v;
    endfunction

    // One measurement: the model decides gate length and outcome, the
    // stimulus then presents the count and optionally one overflow pulse
    // somewhere in the gate or settle window.
    task automatic measure(input bit am, input int rs, input logic [23:0] bcd, input bit ovf);
        int   r;
        int   len;
        int   off;
        res_t e;
        r   = am ? m_auto : rs;
        len = len_tab[r];
        gate_q.push_back(len);
        if (ovf && am && r < 3) begin
            m_auto = r + 1;
        end else begin
            e.bcd = bcd;
            e.rng = 2'(r);
            e.ovr = ovf;
            res_q.push_back(e);
            last_pub = e;
            if (!ovf && am && bcd[23:20] == 4'd0 && r > 0) m_auto = r - 1;
        end
        wait_rise();
        bcd_in = bcd;
        if (am) range_sel = 2'($urandom_range(0, 3));
        if (ovf) begin
            off = $urandom_range(0, len + SET - 1);
            repeat (off) tick();
            overflow_in = 1'b1;
            tick();
            overflow_in = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_clear"}, clear, 1);
        check({tag, "_enable"}, enable, 0);
        check({tag, "_result_bcd"}, result_bcd, 0);
        check({tag, "_range"}, range, 0);
        check({tag, "_result_valid"}, result_valid, 0);
        check({tag, "_over_range"}, over_range, 0);
    endtask

    // Monitor: gate lengths, inter-gate gap, clear width and published results.
    int   cyc = 0;
    bit   en_prev = 1'b0;
    bit   clr_prev = 1'b1;
    int   en_len = 0;
    int   fall_cyc = 0;
    bit   gap_valid = 1'b0;
    bit   run_low = 1'b1;
    int   clr_len = 0;
    bit   clr_from_low = 1'b0;
    bit   clr_run_low = 1'b1;
    res_t mon_e;

    always @(negedge clock) begin
        cyc++;
        if (!reset_n) begin
            en_prev      = 1'b0;
            clr_prev     = 1'b1;
            gap_valid    = 1'b0;
            clr_from_low = 1'b0;
        end else begin
            if (!run) begin
                run_low     = 1'b1;
                clr_run_low = 1'b1;
            end
            if (enable && !en_prev) begin
                if (gap_valid && !run_low) check("enable_gap", cyc - fall_cyc, SET + 1 + CLR);
                en_len = 1;
            end else if (enable) begin
                en_len++;
            end else if (en_prev) begin
                if (gate_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_gate: length %0d, required no gate", en_len);
                end else begin
                    check("gate_len", en_len, gate_q.pop_front());
                end
                fall_cyc  = cyc;
                gap_valid = 1'b1;
                run_low   = !run;
            end
            en_prev = enable;

            if (clear && !clr_prev) begin
                clr_len      = 1;
                clr_from_low = 1'b1;
                clr_run_low  = !run;
            end else if (clear) begin
                clr_len++;
            end else if (clr_prev && clr_from_low && !clr_run_low) begin
                check("clear_len", clr_len, CLR);
            end
            clr_prev = clear;

            if (result_valid) begin
                if (res_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_publish: bcd %06h range %0d, required none",
                             result_bcd, range);
                end else begin
                    mon_e = res_q.pop_front();
                    check("result_bcd", result_bcd, mon_e.bcd);
                    check("result_range", range, mon_e.rng);
                    check("result_over_range", over_range, mon_e.ovr);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        checks++;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        finish_bench();
    end

    initial begin
        // Reset state.
        reset_n = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick();

        // Manual range 0, single measurement.
        auto_range = 1'b0;
        range_sel  = 2'd0;
        run        = 1'b1;
        measure(0, 0, 24'h000123, 0);
        wait_results_drained();
        run = 1'b0;
        repeat (10) tick();

        // Auto ranging: directed walk through up/down ranging and r=3 overflow.
        auto_range = 1'b1;
        run        = 1'b1;
        measure(1, 0, 24'h000000, 1);   // overflow at r0 -> retry at r1
        measure(1, 0, 24'h123456, 0);   // publish r1
        measure(1, 0, 24'h000000, 1);   // -> r2
        measure(1, 0, 24'h012345, 0);   // publish r2, next r1
        measure(1, 0, 24'h900000, 0);   // publish r1 with 100-cycle gate
        measure(1, 0, 24'h000000, 1);   // -> r2
        measure(1, 0, 24'h000000, 1);   // -> r3
        measure(1, 0, 24'h777777, 1);   // overflow at r3 -> over_range publish
        measure(1, 0, 24'h000001, 0);   // r3 held; publish r3, next r2
        for (int i = 0; i < 20; i++) begin
            measure(1, 0, rand_bcd($urandom_range(0, 1) == 0), $urandom_range(0, 2) == 0);
        end
        measure(1, 0, rand_bcd(0), 0);
        wait_results_drained();
        run = 1'b0;
        repeat (10) tick();

        // Abort at gate cycle 50.
        auto_range = 1'b0;
        range_sel  = 2'd0;
        run        = 1'b1;
        gate_q.push_back(50);
        wait_rise();
        repeat (49) tick();
        run = 1'b0;
        tick();
        check("abort_enable", enable, 0);
        check("abort_clear", clear, 1);
        repeat (20) tick();
        check("held_result_bcd", result_bcd, last_pub.bcd);
        check("held_range", range, last_pub.rng);
        check("held_over_range", over_range, last_pub.ovr);

        // Reset in the middle of SETTLE.
        range_sel = 2'd3;
        run       = 1'b1;
        gate_q.push_back(1);
        wait_rise();
        wait_enable(1'b0);
        repeat (5) tick();
        reset_n = 1'b0;
        run     = 1'b0;
        tick();
        check_reset_outputs("settle_reset");
        tick();
        reset_n  = 1'b1;
        m_auto   = 0;
        last_pub = '{24'd0, 2'd0, 1'b0};
        tick();

        // Held auto range restarts at 0 after reset.
        auto_range = 1'b1;
        run        = 1'b1;
        measure(1, 0, 24'h500000, 0);
        wait_results_drained();
        run = 1'b0;
        repeat (10) tick();

        check("gate_queue_empty", gate_q.size(), 0);
        check("result_queue_empty", res_q.size(), 0);
        finish_bench();
    end

endmodule

// File: doc/freq_gate_ctrl.md
# freq_gate_ctrl

Measurement sequencer for the TTL frequency meter. It clears the 6-digit BCD counter chain, then opens a precisely timed gate (`enable`) for it. After the gate closes and the chain settles, it latches the 24-bit BCD count. It auto-ranges the gate time (1 s / 100 ms / 10 ms / 1 ms) on overflow or under-range, and sits between the system clock domain and the counter chain / display path.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: system clock frequency; range-0 gate length in cycles.
- `CLEAR_CYCLES`, 4: cycles `clear` is held before each gate.
- `SETTLE_CYCLES`, 16: cycles waited after gate close before sampling `bcd_in`.

Ports. One clock; reset is synchronous and active-low.
- `clock`, in, 1: system clock; all logic on rising edge.
- `reset_n`, in, 1: synchronous active-low reset.
- `run`, in, 1: level; 1 = continuous measurement, 0 = stop/abort.
- `auto_range`, in, 1: 1 = automatic range; 0 = use `range_sel`.
- `range_sel`, in, 2: manual range, 0..3.
- `bcd_in`, in, 24: counter chain digits `{led_5,…,led_0}`.
- `overflow_in`, in, 1: carry out of the top digit.
- `clear`, out, 1: counter chain clear.
- `enable`, out, 1: gate to the counter chain LSD enable.
- `result_bcd`, out, 24: last published count.
- `range`, out, 2: range of `result_bcd`. Frequency = `result_bcd` × 10^`range` Hz.
- `result_valid`, out, 1: one-cycle pulse on publish.
- `over_range`, out, 1: set with a publish when range 3 overflowed.

## Operation
- States: IDLE, CLEAR, GATE, SETTLE, LATCH.
- IDLE: `clear`=1, `enable`=0. Goes to CLEAR when `run`=1.
- CLEAR: `clear`=1 for exactly CLEAR_CYCLES cycles. The sticky overflow flag is cleared. The active range is loaded: `range_sel` if `auto_range`=0, otherwise the held auto range.
- GATE: `clear`=0, `enable`=1 for exactly gate_len(r) cycles, where gate_len(r) = CLK_HZ/10^r.
- SETTLE: `enable`=0 for SETTLE_CYCLES cycles. `overflow_in`=1 during GATE or SETTLE sets the sticky flag.
- LATCH: one cycle, decides the outcome:
  - sticky=1 and r<3 and auto: r←r+1, go to CLEAR, no publish.
  - sticky=1 and (r=3 or manual): publish with `over_range`=1.
  - sticky=0: publish `bcd_in` with `over_range`=0. If auto and `bcd_in[23:20]`=0 and r>0, next r←r−1; the published `range` stays the measured r.
- Publish sets `result_bcd`, `range`, `over_range` and pulses `result_valid` together, registered on the cycle after LATCH.
- After LATCH: go to CLEAR if `run`=1, otherwise IDLE.
- `run`=0 in CLEAR/GATE/SETTLE: abort. Next state is IDLE, `enable` drops the next cycle, no publish, range unchanged.
- `range_sel` changes only take effect at the next CLEAR.
- Outputs hold their last published values until the next publish.

## Timing
- Reset values: state IDLE, `clear`=1, `enable`=0, `result_bcd`=0, `range`=0, held auto range=0, `result_valid`=0, `over_range`=0, sticky=0.
- All outputs are registered.
- `enable` high-time is exactly gate_len(r) cycles, with no jitter.
- Measurement period = CLEAR_CYCLES + gate_len + SETTLE_CYCLES + 1 (LATCH) cycles.
- Gate counter width: clog2(CLK_HZ+1) bits. It counts down from gate_len−1 to 0 and must not wrap.
- `overflow_in` and `run` are used as-is; synchronizing `overflow_in` is the counter side's responsibility.
- `bcd_in` is sampled only in LATCH. SETTLE_CYCLES covers the settling of `bcd_in` after the gate closes.

## Structure
- Package `freq_ctrl_pkg`: state enum, range constants RANGE_1S..RANGE_1MS (0..3), and a function gate_len(CLK_HZ, r).
- One sub-module, `gate_timer`: loadable down-counter with `load`, `load_val`, and a `done` pulse when it reaches 0. It is reused for the CLEAR, GATE and SETTLE counts.

## Test plan
All tests use CLK_HZ=1000, so gate lengths are 1000/100/10/1.
- Reset, then `run`=1 with manual range 0 and `bcd_in`=24'h000123 → `clear` high 4 cycles, `enable` high exactly 1000 cycles, `result_valid` pulses with `result_bcd`=000123, `range`=0.
- Auto range with `overflow_in` pulsed during gate 0 → no publish, the next gate lasts 100 cycles. With no overflow on that gate, publish with `range`=1.
- Auto range at r=2 with `bcd_in`=24'h012345 → publish with `range`=2, the next gate is 100 cycles (r=1).
- Overflow at r=3 in auto mode → publish with `over_range`=1, `range`=3, and r stays 3.
- `run` dropped at gate cycle 50 → `enable` low the next cycle, state IDLE, `clear`=1, no `result_valid`, previous result held.
- Reset asserted mid-SETTLE → all outputs return to their reset values on the next edge.
